regfile_mp: RTL

Parametrised multi-port register file with write-to-read bypass and a per-register pending scoreboard. It replaces the fixed 16×16, 2-read/1-write register file in the decode stage. Width, depth, read-port count and write-port count are configurable, and the scoreboard lets decode stall on RAW and WAW hazards without external tracking logic.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/rf_scoreboard.sv | 81 ++++++++
 rtl/regfile_mp.sv | 103 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// address-vector types and the constant log2 helper used for address widths.
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 16;
    localparam int MAX_PORTS    = 4;
    localparam int MAX_AW       = 8;

    typedef logic [MAX_AW-1:0]                 reg_addr_t;
    typedef logic [MAX_PORTS-1:0][MAX_AW-1:0]  port_addr_vec_t;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >>> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: tracks issued-but-unwritten destinations,
// grants allocations and resolves the same-cycle set/clear race.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    output logic                 alloc_ok,
    output logic [NUM_REGS-1:0]  pend
);

    logic [NUM_REGS-1:0] pend_r;
    logic [NUM_REGS-1:0] pend_nxt_s;
    logic [NUM_REGS-1:0] wr_hit_s;
    logic                alloc_ok_s;

    // Registers retiring a write this cycle, any port.
    always_comb begin
        wr_hit_s = {NUM_REGS{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
                    wr_hit_s[r] = 1'b1;
                end else begin
                    wr_hit_s[r] = wr_hit_s[r];
                end
            end
        end
        if (ZERO_REG != 0) begin
            wr_hit_s[0] = 1'b0;
        end else begin
            wr_hit_s[0] = wr_hit_s[0];
        end
    end

    // A pending target is only grantable when its producer retires now; held off in reset.
    always_comb begin
        alloc_ok_s = rst_n && alloc_en && (!pend_r[alloc_addr] || wr_hit_s[alloc_addr]);
    end

    // Next pending state: a new allocation overrides a retiring write on the same register.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (alloc_ok_s && (alloc_addr == AW'(r))) begin
                pend_nxt_s[r] = 1'b1;
            end else if (wr_hit_s[r]) begin
                pend_nxt_s[r] = 1'b0;
            end else begin
                pend_nxt_s[r] = pend_r[r];
            end
        end
        if (ZERO_REG != 0) begin
            pend_nxt_s[0] = 1'b0;
        end else begin
            pend_nxt_s[0] = pend_nxt_s[0];
        end
    end

    // Pending-bit state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= {NUM_REGS{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    assign alloc_ok = alloc_ok_s;
    assign pend     = pend_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// optional hardwired zero register and a pending scoreboard for decode stalls.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic                     alloc_ok,
    output logic [NUM_REGS-1:0]      pend
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_r;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_nxt_s;
    logic [NUM_REGS-1:0]             pend_s;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .alloc_ok   (alloc_ok),
        .pend       (pend_s)
    );

    // Write merge: ports are applied in ascending order so the highest index wins a conflict.
    always_comb begin
        regs_nxt_s = regs_r;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
                    regs_nxt_s[r] = wr_data[p*DATA_W +: DATA_W];
                end else begin
                    regs_nxt_s[r] = regs_nxt_s[r];
                end
            end
        end
        if (ZERO_REG != 0) begin
            regs_nxt_s[0] = {DATA_W{1'b0}};
        end else begin
            regs_nxt_s[0] = regs_nxt_s[0];
        end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_r <= {(NUM_REGS*DATA_W){1'b0}};
        end else begin
            regs_r <= regs_nxt_s;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     addr_s;
        logic [DATA_W-1:0] data_s;
        logic              hit_s;

        // Read mux with bypass; the last matching write port overrides earlier ones.
        always_comb begin
            addr_s = rd_addr[i*AW +: AW];
            data_s = regs_r[addr_s];
            hit_s  = 1'b0;
            for (int p = 0; p < NUM_WR; p++) begin
                if ((BYPASS != 0) && wr_en[p] && (wr_addr[p*AW +: AW] == addr_s) &&
                    !((ZERO_REG != 0) && (addr_s == {AW{1'b0}}))) begin
                    data_s = wr_data[p*DATA_W +: DATA_W];
                    hit_s  = 1'b1;
                end else begin
                    data_s = data_s;
                    hit_s  = hit_s;
                end
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data_s;
        assign rd_ready[i]                 = !pend_s[addr_s] || hit_s;
    end

    assign pend = pend_s;

endmodule
